// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants, state encoding and unpacked-operand type for the sequential single-precision subtractor
package fp_pkg;

    localparam int          FP_EXP_W   = 8;
    localparam int          FP_FRAC_W  = 23;
    localparam int          FP_BIAS    = 127;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

    // Working mantissa: [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky
    localparam int MANT_W    = 28;
    localparam int ALIGN_MAX = 27;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } fp_state_t;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [MANT_W-1:0]   mant;
    } fp_unpacked_t;

    // Denormals and zero share the exponent of the smallest normal, hidden bit clear.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign = x[31];
        u.exp  = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        u.mant = {1'b0, (x[30:23] != 8'd0), x[FP_FRAC_W-1:0], 3'b000};
        return u;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - round-to-nearest-even, post-round renormalize, overflow to infinity and pack to 32 bits
//   sign, exp[9:0], mant[27:0] : normalized working result
//   special                    : an operand was inf/NaN, emit the quiet NaN
//   res[31:0]                  : packed IEEE-754 single
module fp_round_pack
    import fp_pkg::*;
(
    input  logic                sign,
    input  logic [9:0]          exp,
    input  logic [MANT_W-1:0]   mant,
    input  logic                special,
    output logic [31:0]         res
);

    logic              inc;
    logic [MANT_W-1:0] mant_r;
    logic [MANT_W-1:0] mant_n;
    logic [9:0]        exp_n;

    always_comb begin
        inc    = mant[2] & (mant[1] | mant[0] | mant[3]);
        mant_r = mant + {24'd0, inc, 3'b000};
        if (mant_r[27]) begin
            mant_n = {1'b0, mant_r[27:1]};
            exp_n  = exp + 10'd1;
        end else begin
            mant_n = mant_r;
            exp_n  = exp;
        end

        if (special) begin
            res = FP_QNAN;
        end else if (exp_n >= 10'd255) begin
            res = {sign, FP_EXP_MAX, {FP_FRAC_W{1'b0}}};
        end else if (!mant_n[26]) begin
            // no hidden bit left: denormal or zero, encoded exponent 0
            res = {sign, 8'd0, mant_n[25:3]};
        end else begin
            res = {sign, exp_n[7:0], mant_n[25:3]};
        end
    end

endmodule

// File: rtl/fp_sub_seq.sv
// rtl/fp_sub_seq.sv - multi-cycle IEEE-754 single-precision subtractor s = a - b with bit-serial align/normalize
//   clk, rst_n                   : clock, synchronous active-low reset
//   in_valid/in_ready, a, b      : operand handshake
//   out_valid/out_ready, s       : result handshake
//   busy                         : FSM not idle
module fp_sub_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] s,
    output logic        busy
);

    fp_state_t         state;
    logic [MANT_W-1:0] mant_big;
    logic [MANT_W-1:0] mant_small;
    logic              sign_big;
    logic              sign_small;
    logic [9:0]        exp_w;
    logic [4:0]        d_cnt;
    logic              special;

    fp_unpacked_t      ua;
    fp_unpacked_t      ub;
    fp_unpacked_t      big_in;
    fp_unpacked_t      small_in;
    logic [7:0]        exp_diff;
    logic              special_in;
    logic [MANT_W-1:0] sum;
    logic              norm_go;
    logic [31:0]       round_res;

    always_comb begin
        ua = fp_unpack(a);
        ub = fp_unpack({~b[31], b[30:0]});
        // larger magnitude by exponent first, then mantissa
        if ({ua.exp, ua.mant} >= {ub.exp, ub.mant}) begin
            big_in   = ua;
            small_in = ub;
        end else begin
            big_in   = ub;
            small_in = ua;
        end
        exp_diff   = big_in.exp - small_in.exp;
        special_in = (ua.exp == FP_EXP_MAX) || (ub.exp == FP_EXP_MAX);
    end

    always_comb begin
        sum     = (sign_big == sign_small) ? (mant_big + mant_small) : (mant_big - mant_small);
        norm_go = !special && !mant_big[26] && (exp_w > 10'd1) && (mant_big != '0);
    end

    fp_round_pack u_round_pack (
        .sign    (sign_big),
        .exp     (exp_w),
        .mant    (mant_big),
        .special (special),
        .res     (round_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            s          <= '0;
            mant_big   <= '0;
            mant_small <= '0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            exp_w      <= '0;
            d_cnt      <= '0;
            special    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_big   <= big_in.sign;
                        sign_small <= small_in.sign;
                        mant_big   <= big_in.mant;
                        mant_small <= small_in.mant;
                        exp_w      <= {2'b00, big_in.exp};
                        special    <= special_in;
                        // past 27 shifts only the sticky bit survives, so the count saturates there
                        if (special_in)
                            d_cnt <= 5'd0;
                        else if (exp_diff > 8'(ALIGN_MAX))
                            d_cnt <= 5'(ALIGN_MAX);
                        else
                            d_cnt <= exp_diff[4:0];
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (d_cnt != 5'd0) begin
                        mant_small <= {1'b0, mant_small[27:2], mant_small[1] | mant_small[0]};
                        d_cnt      <= d_cnt - 5'd1;
                    end else begin
                        state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    if (sum[27]) begin
                        mant_big <= {1'b0, sum[27:2], sum[1] | sum[0]};
                        exp_w    <= exp_w + 10'd1;
                    end else begin
                        mant_big <= sum;
                    end
                    if (sum == '0)
                        sign_big <= 1'b0;
                    state <= ST_NORM;
                end
                ST_NORM: begin
                    if (norm_go) begin
                        mant_big <= {mant_big[26:0], 1'b0};
                        exp_w    <= exp_w - 10'd1;
                    end else begin
                        state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    s         <= round_res;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
